// File: rtl/uart_lite_core.sv
// uart_lite_core: baud-tick divider, TX FIFO + serializer, 2-flop RX synchronizer,
// RX deserializer + RX FIFO. 16 baud ticks per bit, 16550-style line format.
// Optional feature macro: UART_LOOPBACK_EN (RX path fed from stx_pad_o internally).
module uart_lite_core #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       lcr,
  input  logic [7:0]       dl,
  input  logic [7:0]       tdr,
  input  logic             tf_push,
  input  logic             rf_pop,
  input  logic             srx_pad_i,
  output logic             stx_pad_o,
  output logic [CNT_W-1:0] tf_count,
  output logic [CNT_W-1:0] rf_count,
  output logic [7:0]       rdr,
  output logic             rf_error,
  output logic             rf_overrun
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] Full = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [7:0] div_q, div_d;
  logic tick_q, tick_d, run;
  logic [1:0] sync_q, sync_d;
  logic rx_line;
  logic [7:0] tf_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tf_wptr_q, tf_wptr_d, tf_rptr_q, tf_rptr_d;
  logic [CNT_W-1:0] tf_count_q, tf_count_d;
  logic tf_we, tf_pop;
  logic [10:0] rf_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rf_wptr_q, rf_wptr_d, rf_rptr_q, rf_rptr_d;
  logic [CNT_W-1:0] rf_count_q, rf_count_d;
  logic rf_we, rf_re, rf_overrun_q, rf_overrun_d;
  state_e tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [4:0] tx_cnt_q, tx_cnt_d, tx_stop_last;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d, wlast;
  logic [7:0] tx_shr_q, tx_shr_d, tx_head, rx_shr_q, rx_shr_d, rx_data;
  logic tx_xor_q, tx_xor_d, tx_load, tx_par_bit, tx_line;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic rx_par_q, rx_par_d, rx_hold_q, rx_hold_d, rx_push, rx_exp_par;
  logic [10:0] rx_entry, rf_head;

  assign run   = lcr[7] & (dl != 8'd0);
  assign wlast = {1'b1, lcr[1:0]};  // index of last data bit: 4..7

  // Divider: reload dl-1 on zero, registered tick on zero while running
  always_comb begin
    div_d = div_q;
    if (run) div_d = (div_q == 8'd0) ? dl - 8'd1 : div_q - 8'd1;
    tick_d = run & (div_q == 8'd0);
  end

  // RX synchronizer shift
  always_comb sync_d = {sync_q[0], srx_pad_i};

`ifdef UART_LOOPBACK_EN
  assign rx_line = stx_pad_o;
`else
  assign rx_line = sync_q[1];
`endif

  // TX FIFO pointers and occupancy
  assign tf_we   = tf_push & (tf_count_q != Full);
  assign tx_head = tf_mem_q[tf_rptr_q];
  always_comb begin
    tf_wptr_d  = tf_wptr_q;
    tf_rptr_d  = tf_rptr_q;
    tf_count_d = tf_count_q;
    if (tf_we) tf_wptr_d = tf_wptr_q + AW'(1);
    if (tf_pop) tf_rptr_d = tf_rptr_q + AW'(1);
    if (tf_we && !tf_pop) tf_count_d = tf_count_q + CNT_W'(1);
    else if (!tf_we && tf_pop) tf_count_d = tf_count_q - CNT_W'(1);
  end

  // 1.5 stop bits only for 5-bit words with lcr[2] set
  always_comb begin
    tx_stop_last = 5'd15;
    if (lcr[2]) tx_stop_last = (wlast == 3'd4) ? 5'd23 : 5'd31;
  end

  // TX FSM next state; back-to-back frames reload straight from the stop bit
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_shr_d = tx_shr_q;
    tx_xor_d = tx_xor_q;
    tx_load  = 1'b0;
    tf_pop   = 1'b0;
    if (tick_q) begin
      tx_cnt_d = tx_cnt_q + 5'd1;
      unique case (tx_st_q)
        StIdle: begin
          tx_cnt_d = '0;
          tx_load  = (tf_count_q != '0);
        end
        StStart: if (tx_cnt_q == 5'd15) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_st_d  = StData;
        end
        StData: if (tx_cnt_q == 5'd15) begin
          tx_cnt_d = '0;
          tx_shr_d = {1'b0, tx_shr_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == wlast) tx_st_d = lcr[3] ? StParity : StStop;
        end
        StParity: if (tx_cnt_q == 5'd15) begin
          tx_cnt_d = '0;
          tx_st_d  = StStop;
        end
        StStop: if (tx_cnt_q == tx_stop_last) begin
          tx_cnt_d = '0;
          tx_st_d  = StIdle;
          tx_load  = (tf_count_q != '0);
        end
        default: tx_st_d = StIdle;
      endcase
      if (tx_load) begin
        tf_pop   = 1'b1;
        tx_shr_d = tx_head;
        tx_xor_d = ^(tx_head & (8'hFF >> (3'd7 - wlast)));
        tx_st_d  = StStart;
      end
    end
  end

  // TX line drive from state; break forces the pad low without stopping the FSM
  always_comb begin
    tx_par_bit = lcr[5] ? ~lcr[4] : (lcr[4] ? tx_xor_q : ~tx_xor_q);
    unique case (tx_st_q)
      StStart:  tx_line = 1'b0;
      StData:   tx_line = tx_shr_q[0];
      StParity: tx_line = tx_par_bit;
      default:  tx_line = 1'b1;
    endcase
    stx_pad_o = tx_line & ~lcr[6];
  end

  // RX FSM next state; hold blocks re-arming after a framing error until the line is high
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bit_d  = rx_bit_q;
    rx_shr_d  = rx_shr_q;
    rx_par_d  = rx_par_q;
    rx_hold_d = rx_hold_q & ~rx_line;
    rx_push   = 1'b0;
    if (tick_q) begin
      rx_cnt_d = rx_cnt_q + 4'd1;
      unique case (rx_st_q)
        StIdle: begin
          rx_cnt_d = '0;
          if (!rx_hold_q && !rx_line) rx_st_d = StStart;
        end
        StStart: if (rx_cnt_q == 4'd7) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_line ? StIdle : StData;
        end
        StData: if (rx_cnt_q == 4'd15) begin
          rx_shr_d = {rx_line, rx_shr_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == wlast) rx_st_d = lcr[3] ? StParity : StStop;
        end
        StParity: if (rx_cnt_q == 4'd15) begin
          rx_par_d = rx_line;
          rx_st_d  = StStop;
        end
        StStop: if (rx_cnt_q == 4'd15) begin
          rx_push = 1'b1;
          rx_st_d = StIdle;
          if (!rx_line) rx_hold_d = 1'b1;
        end
        default: rx_st_d = StIdle;
      endcase
    end
  end

  // RX entry {data, BI, PE, FE}; samples arrive at the MSB, so shift down short words
  always_comb begin
    rx_data    = rx_shr_q >> (3'd7 - wlast);
    rx_exp_par = lcr[5] ? ~lcr[4] : (lcr[4] ? ^rx_data : ~^rx_data);
    rx_entry   = {rx_data,
                  (rx_data == 8'd0) & ~(lcr[3] & rx_par_q) & ~rx_line,
                  lcr[3] & (rx_par_q != rx_exp_par),
                  ~rx_line};
  end

  // RX FIFO pointers, occupancy and sticky overrun
  assign rf_we   = rx_push & (rf_count_q != Full);
  assign rf_re   = rf_pop & (rf_count_q != '0);
  assign rf_head = rf_mem_q[rf_rptr_q];
  always_comb begin
    rf_wptr_d    = rf_wptr_q;
    rf_rptr_d    = rf_rptr_q;
    rf_count_d   = rf_count_q;
    rf_overrun_d = rf_overrun_q;
    if (rf_we) rf_wptr_d = rf_wptr_q + AW'(1);
    if (rf_re) rf_rptr_d = rf_rptr_q + AW'(1);
    if (rf_we && !rf_re) rf_count_d = rf_count_q + CNT_W'(1);
    else if (!rf_we && rf_re) rf_count_d = rf_count_q - CNT_W'(1);
    if (rf_pop) rf_overrun_d = 1'b0;
    if (rx_push && (rf_count_q == Full)) rf_overrun_d = 1'b1;
  end

  assign tf_count   = tf_count_q;
  assign rf_count   = rf_count_q;
  assign rdr        = (rf_count_q != '0) ? rf_head[10:3] : 8'd0;
  assign rf_error   = (rf_count_q != '0) ? |rf_head[2:0] : 1'b0;
  assign rf_overrun = rf_overrun_q;

  // FIFO storage; contents are only visible through the occupancy-gated outputs
  always_ff @(posedge clk) begin
    if (tf_we) tf_mem_q[tf_wptr_q] <= tdr;
    if (rf_we) rf_mem_q[rf_wptr_q] <= rx_entry;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;  tick_q <= 1'b0;  sync_q <= 2'b11;
      tf_wptr_q <= '0;  tf_rptr_q <= '0;  tf_count_q <= '0;
      rf_wptr_q <= '0;  rf_rptr_q <= '0;  rf_count_q <= '0;  rf_overrun_q <= 1'b0;
      tx_st_q <= StIdle;  tx_cnt_q <= '0;  tx_bit_q <= '0;  tx_shr_q <= '0;  tx_xor_q <= 1'b0;
      rx_st_q <= StIdle;  rx_cnt_q <= '0;  rx_bit_q <= '0;  rx_shr_q <= '0;
      rx_par_q <= 1'b0;  rx_hold_q <= 1'b0;
    end else begin
      div_q <= div_d;  tick_q <= tick_d;  sync_q <= sync_d;
      tf_wptr_q <= tf_wptr_d;  tf_rptr_q <= tf_rptr_d;  tf_count_q <= tf_count_d;
      rf_wptr_q <= rf_wptr_d;  rf_rptr_q <= rf_rptr_d;  rf_count_q <= rf_count_d;
      rf_overrun_q <= rf_overrun_d;
      tx_st_q <= tx_st_d;  tx_cnt_q <= tx_cnt_d;  tx_bit_q <= tx_bit_d;
      tx_shr_q <= tx_shr_d;  tx_xor_q <= tx_xor_d;
      rx_st_q <= rx_st_d;  rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;  rx_shr_q <= rx_shr_d;
      rx_par_q <= rx_par_d;  rx_hold_q <= rx_hold_d;
    end
  end

endmodule

// File: tb/tb_uart_lite_core.sv
// Directed self-checking bench for uart_lite_core. The bench can route stx_pad_o back
// into srx_pad_i externally to exercise the TX->RX path in the default build.
module tb_uart_lite_core;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] lcr, dl, tdr;
  logic       tf_push, rf_pop, srx_drv, lb, srx;
  logic       stx;
  logic [4:0] tf_count, rf_count;
  logic [7:0] rdr;
  logic       rf_error, rf_overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign srx = lb ? stx : srx_drv;

  uart_lite_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lcr       (lcr),
    .dl        (dl),
    .tdr       (tdr),
    .tf_push   (tf_push),
    .rf_pop    (rf_pop),
    .srx_pad_i (srx),
    .stx_pad_o (stx),
    .tf_count  (tf_count),
    .rf_count  (rf_count),
    .rdr       (rdr),
    .rf_error  (rf_error),
    .rf_overrun(rf_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    tdr = d;  tf_push = 1'b1;
    @(negedge clk);
    tf_push = 1'b0;
  endtask

  task automatic pop();
    rf_pop = 1'b1;
    @(negedge clk);
    rf_pop = 1'b0;
  endtask

  task automatic wait_stx_fall(output bit found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (stx == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // 8-bit frame on srx_drv, bclk clocks per bit, two idle bit times after stop
  task automatic rx_frame(input logic [7:0] d, input bit pen, input bit pbit, input int bclk);
    srx_drv = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      srx_drv = d[i];
      repeat (bclk) @(negedge clk);
    end
    if (pen) begin
      srx_drv = pbit;
      repeat (bclk) @(negedge clk);
    end
    srx_drv = 1'b1;
    repeat (2 * bclk) @(negedge clk);
  endtask

  initial begin
    bit found;
    int low_len, not_idle;
    logic [7:0] exp_bits;

    rst_n = 1'b0;  lcr = 8'h00;  dl = 8'd0;  tdr = 8'h00;
    tf_push = 1'b0;  rf_pop = 1'b0;  srx_drv = 1'b1;  lb = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_stx", {31'd0, stx}, 1);
    check("reset_tf_count", {27'd0, tf_count}, 0);
    check("reset_rf_count", {27'd0, rf_count}, 0);
    check("reset_rdr", {24'd0, rdr}, 0);
    check("reset_rf_error", {31'd0, rf_error}, 0);
    check("reset_rf_overrun", {31'd0, rf_overrun}, 0);
    rst_n = 1'b1;

    // Divider stopped (lcr[7]=0): data stays queued, line stays idle
    lcr = 8'h03;  dl = 8'd4;
    @(negedge clk);
    push(8'hA5);
    not_idle = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (stx !== 1'b1) not_idle++;
    end
    check("frozen_tf_count", {27'd0, tf_count}, 1);
    check("frozen_stx_not_idle_cycles", not_idle, 0);

    // 8N1 at dl=4: 64 clocks per bit
    do_reset();
    lcr = 8'h83;
    push(8'h55);
    wait_stx_fall(found);
    check("tx_start_seen", {31'd0, found}, 1);
    check("tx_tf_count_after_pop", {27'd0, tf_count}, 0);
    low_len = 1;
    while (low_len < 300) begin
      @(negedge clk);
      if (stx !== 1'b0) break;
      low_len++;
    end
    check("tx_start_len", low_len, 64);
    repeat (32) @(negedge clk);
    exp_bits = 8'h55;
    for (int b = 0; b < 8; b++) begin
      check($sformatf("tx_bit%0d", b), {31'd0, stx}, {31'd0, exp_bits[b]});
      repeat (64) @(negedge clk);
    end
    check("tx_stop", {31'd0, stx}, 1);
    lcr = 8'hC3;
    @(negedge clk);
    check("tx_break_low", {31'd0, stx}, 0);
    lcr = 8'h83;
    @(negedge clk);
    check("tx_break_release", {31'd0, stx}, 1);

    // 8E1 at dl=2 (32 clocks per bit): wrong parity then correct parity
    do_reset();
    lcr = 8'h9B;  dl = 8'd2;
    rx_frame(8'h3C, 1'b1, 1'b1, 32);
    check("rx_pe_count", {27'd0, rf_count}, 1);
    check("rx_pe_rdr", {24'd0, rdr}, 32'h3C);
    check("rx_pe_error", {31'd0, rf_error}, 1);
    pop();
    check("rx_pop_count", {27'd0, rf_count}, 0);
    check("rx_pop_rdr", {24'd0, rdr}, 0);
    pop();
    check("rx_pop_empty_count", {27'd0, rf_count}, 0);
    rx_frame(8'h3C, 1'b1, 1'b0, 32);
    check("rx_ok_rdr", {24'd0, rdr}, 32'h3C);
    check("rx_ok_error", {31'd0, rf_error}, 0);
    pop();

    // Break: line low 12 bit times gives one BI/FE entry, then re-arm only after high
    srx_drv = 1'b0;
    repeat (12 * 32) @(negedge clk);
    check("brk_count_while_low", {27'd0, rf_count}, 1);
    srx_drv = 1'b1;
    repeat (64) @(negedge clk);
    check("brk_count_after_high", {27'd0, rf_count}, 1);
    check("brk_rdr", {24'd0, rdr}, 0);
    check("brk_error", {31'd0, rf_error}, 1);
    rx_frame(8'hA5, 1'b1, 1'b0, 32);
    check("brk_next_count", {27'd0, rf_count}, 2);
    pop();
    check("brk_next_rdr", {24'd0, rdr}, 32'hA5);
    check("brk_next_error", {31'd0, rf_error}, 0);
    pop();

    // Overrun: 17 frames 8N1 at dl=1 with no pops
    do_reset();
    lcr = 8'h83;  dl = 8'd1;
    for (int f = 0; f < 17; f++) rx_frame(8'h10 + 8'(f), 1'b0, 1'b0, 16);
    check("ovr_count", {27'd0, rf_count}, 16);
    check("ovr_flag", {31'd0, rf_overrun}, 1);
    check("ovr_head", {24'd0, rdr}, 32'h10);
    pop();
    check("ovr_cleared", {31'd0, rf_overrun}, 0);
    check("ovr_count_after_pop", {27'd0, rf_count}, 15);
    check("ovr_next_head", {24'd0, rdr}, 32'h11);

    // TX->RX loop, 8N2 at dl=1
    do_reset();
    lb = 1'b1;  lcr = 8'h87;
    push(8'h00);  push(8'hFF);  push(8'h81);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rf_count == 5'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("lb_three_received", {31'd0, found}, 1);
    repeat (300) @(negedge clk);
    check("lb_rdr0", {24'd0, rdr}, 32'h00);
    check("lb_err0", {31'd0, rf_error}, 0);
    pop();
    check("lb_rdr1", {24'd0, rdr}, 32'hFF);
    check("lb_err1", {31'd0, rf_error}, 0);
    pop();
    check("lb_rdr2", {24'd0, rdr}, 32'h81);
    check("lb_err2", {31'd0, rf_error}, 0);
    pop();

    // Reset mid-frame
    push(8'h5A);  push(8'h5B);
    wait_stx_fall(found);
    check("mid_start_seen", {31'd0, found}, 1);
    repeat (8) @(negedge clk);
    check("mid_tf_count", {27'd0, tf_count}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stx", {31'd0, stx}, 1);
    check("mid_rst_tf_count", {27'd0, tf_count}, 0);
    check("mid_rst_rf_count", {27'd0, rf_count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
